// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and entry type for the instruction fetch stage
package if_pkg;

   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, used for the fetch buffer and in-flight PC queue
module fetch_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic [63:0]
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  T                           push_data_i,
   input  logic                       pop_i,
   output T                           head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T              mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Flush wins over push and pop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push_i && !do_pop)      count_q <= count_q + CW'(1);
         else if (!push_i && do_pop) count_q <= count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !flush_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC ownership, credit-throttled requests, redirect drop
module if_stage
   import if_pkg::*;
#(
   parameter logic [63:0] PC_RESET   = PC_RESET_DEFAULT,
   parameter int          FIFO_DEPTH = 2,
   parameter int          CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [63:0] id_pc,
   output logic        id_fault
);

   logic [63:0]    pc_q, pc_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W-1:0] buf_count, pcq_count;
   logic [CNT_W:0]   credit_used;
   logic           req_hs, rsp_keep, buf_pop;
   logic [63:0]    rsp_pc;
   fetch_entry_t   push_entry, head;

   // Buffered plus outstanding entries never exceed the buffer depth.
   assign credit_used    = {1'b0, inflight_q} + {1'b0, buf_count};
   assign imem_req_valid = rst_n && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
   assign imem_req_addr  = pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
   assign buf_pop        = id_valid && id_ready && !redirect_valid;

   assign push_entry.pc    = rsp_pc;
   assign push_entry.inst  = imem_rsp_err ? INST_NOP : imem_rsp_data;
   assign push_entry.fault = imem_rsp_err;

   assign id_valid = (buf_count != '0);
   assign id_inst  = id_valid ? head.inst  : INST_NOP;
   assign id_pc    = id_valid ? head.pc    : 64'h0;
   assign id_fault = id_valid ? head.fault : 1'b0;

   always_comb begin
      inflight_d = inflight_q + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);
      pc_d       = pc_q;
      drop_d     = drop_q;
      if (redirect_valid) begin
         pc_d   = redirect_pc & ~64'h3;
         drop_d = inflight_d;
      end else begin
         if (req_hs) pc_d = pc_q + 64'd4;
         if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= PC_RESET;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [63:0])) u_pc_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (redirect_valid),
      .push_i      (req_hs && !redirect_valid),
      .push_data_i (pc_q),
      .pop_i       (rsp_keep),
      .head_o      (rsp_pc),
      .count_o     (pcq_count)
   );

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_inst_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (redirect_valid),
      .push_i      (rsp_keep),
      .push_data_i (push_entry),
      .pop_i       (buf_pop),
      .head_o      (head),
      .count_o     (buf_count)
   );

   a_pc_available: assert property (@(posedge clk) disable iff (!rst_n)
      rsp_keep |-> pcq_count != '0);

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        imem_rsp_err = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b1;
   logic [31:0] id_inst;
   logic [63:0] id_pc;
   logic        id_fault;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_pc;
   bit          mem_hold = 1'b0;
   bit          err_en = 1'b0;
   logic [63:0] err_addr = '0;
   logic [63:0] mq[$];
   logic [63:0] rsp_a;

   if_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_fault       (id_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [63:0] a);
      return a[31:0] ^ 32'hC3C3_0000;
   endfunction

   // Memory: accepts at posedge, answers in order at the following negedge unless held.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mq.delete();
      else if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
   end

   always @(negedge clk) begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      if (rst_n && !mem_hold && mq.size() > 0) begin
         rsp_a          = mq.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word(rsp_a);
         imem_rsp_err   = err_en && (rsp_a == err_addr);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
      checks++; if (id_inst !== NOP) begin errors++; $display("FAIL reset_id_inst: got %h expected %h", id_inst, NOP); end
      checks++; if (id_pc !== 64'h0) begin errors++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
      checks++; if (id_fault !== 1'b0) begin errors++; $display("FAIL reset_id_fault: got %b expected 0", id_fault); end
   endtask

   task automatic test_stream();
      int got = 0;
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL first_req: got valid=%b addr=%h expected 1 80000000", imem_req_valid, imem_req_addr); end
      step();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL early_id_valid: got %b expected 0", id_valid); end
      step();
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_0000) begin errors++; $display("FAIL first_id: got valid=%b pc=%h expected 1 80000000", id_valid, id_pc); end
      exp_pc = 64'h8000_0000;
      repeat (12) begin
         if (id_valid) begin
            checks++;
            if (id_pc !== exp_pc || id_inst !== word(exp_pc) || id_fault !== 1'b0) begin errors++; $display("FAIL stream_entry: got pc=%h inst=%h fault=%b expected pc=%h inst=%h fault=0", id_pc, id_inst, id_fault, exp_pc, word(exp_pc)); end
            exp_pc += 64'd4;
            got++;
         end
         step();
      end
      checks++; if (got < 4) begin errors++; $display("FAIL stream_count: got %0d expected at least 4", got); end
   endtask

   task automatic test_backpressure();
      id_ready = 1'b0;
      repeat (10) step();
      checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_inst !== word(exp_pc)) begin errors++; $display("FAIL bp_head: got valid=%b pc=%h inst=%h expected 1 %h %h", id_valid, id_pc, id_inst, exp_pc, word(exp_pc)); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
      id_ready = 1'b1;
      exp_pc += 64'd4;
      step();
      checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc) begin errors++; $display("FAIL bp_second: got valid=%b pc=%h expected 1 %h", id_valid, id_pc, exp_pc); end
      exp_pc += 64'd4;
      step();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_depth: got valid=%b expected 0", id_valid); end
      repeat (8) begin
         if (id_valid) begin
            checks++;
            if (id_pc !== exp_pc || id_inst !== word(exp_pc)) begin errors++; $display("FAIL bp_resume: got pc=%h inst=%h expected pc=%h inst=%h", id_pc, id_inst, exp_pc, word(exp_pc)); end
            exp_pc += 64'd4;
         end
         step();
      end
   endtask

   task automatic test_req_stall();
      logic [63:0] held;
      imem_req_ready = 1'b0;
      repeat (6) begin
         if (id_valid) begin
            checks++;
            if (id_pc !== exp_pc || id_inst !== word(exp_pc)) begin errors++; $display("FAIL stall_drain: got pc=%h inst=%h expected pc=%h", id_pc, id_inst, exp_pc); end
            exp_pc += 64'd4;
         end
         step();
      end
      held = imem_req_addr;
      checks++; if (imem_req_valid !== 1'b1 || held !== exp_pc) begin errors++; $display("FAIL stall_addr: got valid=%b addr=%h expected 1 %h", imem_req_valid, held, exp_pc); end
      repeat (5) begin
         step();
         checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== held) begin errors++; $display("FAIL stall_hold: got valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, held); end
      end
      imem_req_ready = 1'b1;
      repeat (8) begin
         if (id_valid) begin
            checks++;
            if (id_pc !== exp_pc || id_inst !== word(exp_pc)) begin errors++; $display("FAIL stall_resume: got pc=%h inst=%h expected pc=%h", id_pc, id_inst, exp_pc); end
            exp_pc += 64'd4;
         end
         step();
      end
   endtask

   task automatic test_redirect_inflight();
      bit found = 1'b0;
      int got = 0;
      mem_hold = 1'b1;
      repeat (4) begin
         if (id_valid) begin
            checks++;
            if (id_pc !== exp_pc) begin errors++; $display("FAIL rd_drain: got pc=%h expected %h", id_pc, exp_pc); end
            exp_pc += 64'd4;
         end
         step();
      end
      checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL rd_two_inflight: got req_valid=%b id_valid=%b expected 0 0", imem_req_valid, id_valid); end
      checks++; if (imem_req_addr !== exp_pc + 64'd8) begin errors++; $display("FAIL rd_old_addr: got %h expected %h", imem_req_addr, exp_pc + 64'd8); end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_1002;
      step();
      redirect_valid = 1'b0;
      mem_hold       = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_stale: got valid=%b pc=%h expected valid 0", id_valid, id_pc); end
         if (imem_req_valid) found = 1'b1;
         else step();
      end
      checks++; if (!found || imem_req_addr !== 64'h8000_1000) begin errors++; $display("FAIL rd_new_addr: got found=%b addr=%h expected 1 80001000", found, imem_req_addr); end
      exp_pc = 64'h8000_1000;
      repeat (10) begin
         if (id_valid) begin
            checks++;
            if (id_pc !== exp_pc || id_inst !== word(exp_pc)) begin errors++; $display("FAIL rd_entry: got pc=%h inst=%h expected pc=%h inst=%h", id_pc, id_inst, exp_pc, word(exp_pc)); end
            exp_pc += 64'd4;
            got++;
         end
         step();
      end
      checks++; if (got == 0) begin errors++; $display("FAIL rd_progress: got 0 entries expected at least 1"); end
   endtask

   task automatic test_redirect_same_cycle();
      bit found = 1'b0;
      int got = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req_valid && imem_req_ready && mq.size() > 0) found = 1'b1;
         else begin
            if (id_valid) exp_pc += 64'd4;
            step();
         end
      end
      checks++; if (!found) begin errors++; $display("FAIL rs_setup: got no cycle with request and response expected one within 10"); end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_2000;
      step();
      redirect_valid = 1'b0;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rs_flush: got valid=%b expected 0", id_valid); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000) begin errors++; $display("FAIL rs_new_req: got valid=%b addr=%h expected 1 80002000", imem_req_valid, imem_req_addr); end
      exp_pc = 64'h8000_2000;
      repeat (10) begin
         if (id_valid) begin
            checks++;
            if (id_pc !== exp_pc || id_inst !== word(exp_pc)) begin errors++; $display("FAIL rs_entry: got pc=%h inst=%h expected pc=%h inst=%h", id_pc, id_inst, exp_pc, word(exp_pc)); end
            exp_pc += 64'd4;
            got++;
         end
         step();
      end
      checks++; if (got == 0) begin errors++; $display("FAIL rs_progress: got 0 entries expected at least 1"); end
   endtask

   task automatic test_err();
      int saw = 0;
      bit ef;
      err_en   = 1'b1;
      err_addr = 64'h8000_3008;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_3000;
      step();
      redirect_valid = 1'b0;
      exp_pc = 64'h8000_3000;
      repeat (14) begin
         if (id_valid) begin
            ef = (exp_pc == 64'h8000_3008);
            checks++;
            if (id_pc !== exp_pc || id_fault !== ef || id_inst !== (ef ? NOP : word(exp_pc))) begin errors++; $display("FAIL err_entry: got pc=%h inst=%h fault=%b expected pc=%h fault=%b", id_pc, id_inst, id_fault, exp_pc, ef); end
            if (id_fault) saw++;
            exp_pc += 64'd4;
         end
         step();
      end
      checks++; if (saw != 1 || exp_pc <= 64'h8000_300C) begin errors++; $display("FAIL err_count: got faults=%0d next_pc=%h expected 1 beyond 8000300c", saw, exp_pc); end
      err_en = 1'b0;
   endtask

   task automatic test_reset_midop();
      int got = 0;
      rst_n = 1'b0;
      #1;
      checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || id_pc !== 64'h0 || id_inst !== NOP) begin errors++; $display("FAIL midreset_outputs: got id_valid=%b req_valid=%b pc=%h inst=%h expected 0 0 0 %h", id_valid, imem_req_valid, id_pc, id_inst, NOP); end
      step();
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL midreset_req: got valid=%b addr=%h expected 1 80000000", imem_req_valid, imem_req_addr); end
      exp_pc = 64'h8000_0000;
      repeat (8) begin
         if (id_valid) begin
            checks++;
            if (id_pc !== exp_pc || id_inst !== word(exp_pc)) begin errors++; $display("FAIL midreset_entry: got pc=%h inst=%h expected pc=%h", id_pc, id_inst, exp_pc); end
            exp_pc += 64'd4;
            got++;
         end
         step();
      end
      checks++; if (got == 0) begin errors++; $display("FAIL midreset_progress: got 0 entries expected at least 1"); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_req_stall();
      test_redirect_inflight();
      test_redirect_same_cycle();
      test_err();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
